fb_hazard_ctrl: RTL and testbench

Pipeline hazard scheduler for the 5-stage Firebird core.
- Consumes the decoded control bits (mem_read, branch/jump redirect) carried down the ID/EX and EX/MEM registers, plus the data-memory ready handshake.
- Sequences stalls, bubbles and flushes across the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the data-memory wait state machine, including a timeout to a sticky error state.

---
 rtl/fb_hazard_ctrl_pkg.sv | 35 +++
 rtl/fb_mem_wait_timer.sv | 23 ++
 rtl/fb_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_fb_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fb_hazard_ctrl_pkg.sv
// Shared encodings for the Firebird hazard scheduler: FSM states, register
// index width and the per-cycle pipeline control bundle.
package fb_hazard_ctrl_pkg;

  localparam int FB_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
    logic pc_redirect;
  } hz_ctl_t;

  function automatic hz_ctl_t hz_freeze();
    hz_ctl_t c;
    c               = '0;
    c.pc_stall      = 1'b1;
    c.if_id_stall   = 1'b1;
    c.id_ex_stall   = 1'b1;
    c.ex_mem_stall  = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/fb_mem_wait_timer.sv
// Saturating 8-bit wait counter. clr has priority and loads the inc bit,
// so clr&inc starts a fresh wait at 1; expire flags MEM_TIMEOUT-1.
module fb_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= {7'd0, inc};
    else if (inc && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  assign expire = (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/fb_hazard_ctrl.sv
// Firebird 5-stage hazard scheduler: load-use bubbles, redirect flushes and
// the data-memory wait FSM. Optional perf counters under FB_HAZARD_PERF_EN.
module fb_hazard_ctrl
  import fb_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_ADDR_W  = FB_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic                  pc_redirect,
  output logic                  mem_err,
  output logic [1:0]            state
`ifdef FB_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_bubble_cnt
`endif
);

  hz_state_t st_q, st_nxt;
  hz_ctl_t   ctl, run_ctl;
  logic      load_use, run_bubble, bubble;
  logic      t_clr, t_inc, t_expire, err_set;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) ||
                     (id_use_rs2 && id_rs2 == ex_rd));

  // Redirect/load-use response, shared by S_RUN and the wait-exit cycle.
  always_comb begin
    run_ctl    = '0;
    run_bubble = 1'b0;
    if (ex_redirect) begin
      run_ctl.pc_redirect = 1'b1;
      run_ctl.if_id_flush = 1'b1;
      run_ctl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      run_ctl.pc_stall    = 1'b1;
      run_ctl.if_id_stall = 1'b1;
      run_ctl.id_ex_flush = 1'b1;
      run_bubble          = 1'b1;
    end
  end

  always_comb begin
    ctl     = '0;
    bubble  = 1'b0;
    st_nxt  = st_q;
    t_clr   = 1'b0;
    t_inc   = 1'b0;
    err_set = 1'b0;
    unique case (st_q)
      S_RUN: begin
        if (mem_req && !dmem_ready) begin
          ctl    = hz_freeze();
          st_nxt = S_MEM_WAIT;
          t_clr  = 1'b1;
          t_inc  = 1'b1;
        end else begin
          ctl    = run_ctl;
          bubble = run_bubble;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          ctl    = run_ctl;
          bubble = run_bubble;
          st_nxt = S_RUN;
        end else begin
          ctl = hz_freeze();
          if (t_expire) begin
            st_nxt  = S_ERR;
            err_set = 1'b1;
          end else begin
            t_inc = 1'b1;
          end
        end
      end
      S_ERR:   ctl = hz_freeze();
      default: st_nxt = S_RUN;
    endcase
    if (rst) begin
      ctl    = '0;
      bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_RUN;
      mem_err <= 1'b0;
    end else begin
      st_q <= st_nxt;
      if (err_set)
        mem_err <= 1'b1;
    end
  end

  fb_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .clr    (rst | t_clr),
    .inc    (t_inc),
    .expire (t_expire)
  );

  assign pc_stall      = ctl.pc_stall;
  assign if_id_stall   = ctl.if_id_stall;
  assign id_ex_stall   = ctl.id_ex_stall;
  assign ex_mem_stall  = ctl.ex_mem_stall;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_flush   = ctl.id_ex_flush;
  assign mem_wb_bubble = ctl.mem_wb_bubble;
  assign pc_redirect   = ctl.pc_redirect;
  assign state         = st_q;

`ifdef FB_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (st_q != S_ERR) begin
      perf_stall_cnt  <= perf_stall_cnt  + 32'(ctl.pc_stall);
      perf_flush_cnt  <= perf_flush_cnt  + 32'(ctl.pc_redirect);
      perf_bubble_cnt <= perf_bubble_cnt + 32'(bubble);
    end
  end
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_fb_hazard_ctrl.sv
// Scoreboard bench for fb_hazard_ctrl: directed hazard scenarios then random
// traffic, checked against a cycle-level behavioural model of the scheduler.
module tb_fb_hazard_ctrl;

  localparam int T = 4;
  localparam logic [7:0] FRZ = 8'b1111_0010;
  localparam logic [7:0] RDR = 8'b0000_1101;
  localparam logic [7:0] LU  = 8'b1100_0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic       ex_redirect = 0, mem_req = 0, dmem_ready = 0;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, pc_redirect, mem_err;
  logic [1:0] state;
`ifdef FB_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fb_hazard_ctrl #(.MEM_TIMEOUT(T), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .pc_redirect(pc_redirect), .mem_err(mem_err), .state(state)
`ifdef FB_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic        err;
    logic [31:0] ps, pf, pb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Model: mode flags plus the count of frozen cycles in the current wait.
  bit          m_wait = 0, m_err = 0;
  int          waited = 0;
  logic [31:0] ps = 0, pf = 0, pb = 0;

  task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                      input bit redir, input bit mreq, input bit rdy);
    exp_t e;
    bit lu, bub, was_err;
    logic [7:0] hz;
    @(posedge clk); #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_redirect = redir; mem_req = mreq; dmem_ready = rdy;
    e.st  = m_err ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    e.err = m_err;
    e.ps = ps; e.pf = pf; e.pb = pb;
    lu  = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    hz  = redir ? RDR : (lu ? LU : 8'h00);
    bub = 0;
    was_err = m_err;
    if (r) begin
      e.ctl = 8'h00; m_wait = 0; m_err = 0; waited = 0;
    end else if (m_err) begin
      e.ctl = FRZ;
    end else if (m_wait && rdy) begin
      e.ctl = hz; bub = !redir && lu; m_wait = 0;
    end else if (m_wait) begin
      e.ctl = FRZ; waited++;
      if (waited == T) begin m_wait = 0; m_err = 1; end
    end else if (mreq && !rdy) begin
      e.ctl = FRZ; m_wait = 1; waited = 1;
    end else begin
      e.ctl = hz; bub = !redir && lu;
    end
    if (r) begin
      ps = 0; pf = 0; pb = 0;
    end else if (!was_err) begin
      ps += 32'(e.ctl[7]); pf += 32'(e.ctl[0]); pb += 32'(bub);
    end
    q.push_back(e);
  endtask

  task automatic idle(input bit r);
    step(r, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_bubble, pc_redirect};
        total++;
        if (act !== e.ctl) begin
          bad++; $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
        end
        total++;
        if (state !== e.st) begin
          bad++; $display("FAIL state t=%0t got=%0d want=%0d", $time, state, e.st);
        end
        total++;
        if (mem_err !== e.err) begin
          bad++; $display("FAIL mem_err t=%0t got=%b want=%b", $time, mem_err, e.err);
        end
`ifdef FB_HAZARD_PERF_EN
        total++;
        if (perf_stall_cnt !== e.ps || perf_flush_cnt !== e.pf || perf_bubble_cnt !== e.pb) begin
          bad++;
          $display("FAIL perf t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                   perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt, e.ps, e.pf, e.pb);
        end
`endif
      end
    end
  end

  initial begin : stim
    idle(1); idle(1);
    // lw x5 in EX, ID reads rs2=x5 -> one bubble, then the bubble sits in EX
    step(0, 5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
    step(0, 5'd1, 5'd5, 1, 1, 0, 5'd0, 0, 0, 0);
    // memory wait: ready 3 cycles late, then the ready cycle
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
    idle(0);
`ifdef FB_HAZARD_PERF_EN
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== 32'd4 || perf_bubble_cnt !== 32'd1) begin
      bad++;
      $display("FAIL perf_scen got stall=%0d bubble=%0d want stall=4 bubble=1",
               perf_stall_cnt, perf_bubble_cnt);
    end
`endif
    // x0 never creates a hazard; redirect overrides load-use
    step(0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0);
    step(0, 5'd3, 5'd0, 1, 0, 1, 5'd3, 1, 0, 0);
    // redirect masked during a wait, honoured after ready
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
    // ready with the request: no stall, load-use applies
    step(0, 5'd2, 5'd0, 1, 0, 1, 5'd2, 0, 1, 1);
    // timeout into the sticky error state, then reset out of it
    for (int i = 0; i < T + 3; i++)
      step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, (i == 2), 1, 0);
    idle(1);
    idle(0);
    idle(0);
    // random traffic over a small register range to hit hazards often
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 59) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0));
    @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
